// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller types and constants.
// Store sequencer state encoding and output vectors.
package mem_ctrl_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      STORE = 1'b1
   } store_state_t;

   // Output vector order: {memWrite, regOut, swEnable}
   localparam logic [2:0] OUT_IDLE  = 3'b000;
   localparam logic [2:0] OUT_STORE = 3'b111;

endpackage

// File: rtl/store_state_machine.sv
// Two-state Moore sequencer for a memory store.
// Drives write strobe, reg output enable and path switch.
module store_state_machine
   import mem_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rstN,
   input  logic opendFlag,
   input  logic storeEnd,
   output logic memWrite,
   output logic regOut,
   output logic swEnable
);

   store_state_t state;
   store_state_t next_state;
   logic [2:0]   out_vec;

   // State register; reset aborts any store in progress
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and state-only output decode
   always_comb begin
      next_state = IDLE;
      out_vec    = OUT_IDLE;
      case (state)
         IDLE: begin
            out_vec    = OUT_IDLE;
            next_state = opendFlag ? STORE : IDLE;
         end
         STORE: begin
            out_vec    = OUT_STORE;
            next_state = storeEnd ? IDLE : STORE;
         end
         default: begin
            out_vec    = OUT_IDLE;
            next_state = IDLE;
         end
      endcase
   end

   assign memWrite = out_vec[2];
   assign regOut   = out_vec[1];
   assign swEnable = out_vec[0];

endmodule

// File: tb/tb_store_state_machine.sv
// Directed bench for the store sequencer.
// Each task drives a scenario and checks outputs inline.
module tb_store_state_machine;

   logic clk;
   logic rstN;
   logic opendFlag;
   logic storeEnd;
   logic memWrite;
   logic regOut;
   logic swEnable;

   int checks;
   int errors;

   store_state_machine dut (
      .clk       (clk),
      .rstN      (rstN),
      .opendFlag (opendFlag),
      .storeEnd  (storeEnd),
      .memWrite  (memWrite),
      .regOut    (regOut),
      .swEnable  (swEnable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [2:0] obs;
      rstN = 1'b0; opendFlag = 1'b1; storeEnd = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {memWrite, regOut, swEnable};
         checks++;
         if (obs !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold%0d got %b want 000", i, obs);
         end
      end
      rstN = 1'b1;
      tick();
      obs = {memWrite, regOut, swEnable};
      checks++;
      if (obs !== 3'b111) begin
         errors++;
         $display("FAIL reset_release got %b want 111", obs);
      end
   endtask

   task automatic test_entry();
      logic [2:0] obs;
      rstN = 1'b0; opendFlag = 1'b0; storeEnd = 1'b0;
      tick();
      rstN = 1'b1;
      tick();
      obs = {memWrite, regOut, swEnable};
      checks++;
      if (obs !== 3'b000) begin
         errors++;
         $display("FAIL idle_stay got %b want 000", obs);
      end
      opendFlag = 1'b1;
      tick();
      obs = {memWrite, regOut, swEnable};
      checks++;
      if (obs !== 3'b111) begin
         errors++;
         $display("FAIL entry got %b want 111", obs);
      end
   endtask

   task automatic test_hold();
      logic [2:0] obs;
      opendFlag = 1'b0; storeEnd = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {memWrite, regOut, swEnable};
         checks++;
         if (obs !== 3'b111) begin
            errors++;
            $display("FAIL hold%0d got %b want 111", i, obs);
         end
      end
   endtask

   task automatic test_exit();
      logic [2:0] obs;
      storeEnd = 1'b1; opendFlag = 1'b0;
      tick();
      obs = {memWrite, regOut, swEnable};
      checks++;
      if (obs !== 3'b000) begin
         errors++;
         $display("FAIL exit got %b want 000", obs);
      end
      storeEnd = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {memWrite, regOut, swEnable};
         checks++;
         if (obs !== 3'b000) begin
            errors++;
            $display("FAIL idle_after%0d got %b want 000", i, obs);
         end
      end
      storeEnd = 1'b1;
      tick();
      obs = {memWrite, regOut, swEnable};
      checks++;
      if (obs !== 3'b000) begin
         errors++;
         $display("FAIL idle_ignore_end got %b want 000", obs);
      end
   endtask

   task automatic test_min_dwell();
      logic [2:0] obs;
      opendFlag = 1'b1; storeEnd = 1'b1;
      tick();
      obs = {memWrite, regOut, swEnable};
      checks++;
      if (obs !== 3'b111) begin
         errors++;
         $display("FAIL dwell_entry got %b want 111", obs);
      end
      opendFlag = 1'b0;
      tick();
      obs = {memWrite, regOut, swEnable};
      checks++;
      if (obs !== 3'b000) begin
         errors++;
         $display("FAIL dwell_exit got %b want 000", obs);
      end
   endtask

   task automatic test_priority();
      logic [2:0] obs;
      logic [2:0] exp;
      opendFlag = 1'b1; storeEnd = 1'b0;
      tick();
      obs = {memWrite, regOut, swEnable};
      checks++;
      if (obs !== 3'b111) begin
         errors++;
         $display("FAIL prio_setup got %b want 111", obs);
      end
      storeEnd = 1'b1;
      exp = 3'b000;
      for (int i = 0; i < 4; i++) begin
         tick();
         obs = {memWrite, regOut, swEnable};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL prio_toggle%0d got %b want %b", i, obs, exp);
         end
         exp = ~exp;
      end
   endtask

   task automatic test_mid_store_reset();
      logic [2:0] obs;
      opendFlag = 1'b1; storeEnd = 1'b0;
      tick();
      obs = {memWrite, regOut, swEnable};
      checks++;
      if (obs !== 3'b111) begin
         errors++;
         $display("FAIL mrst_setup got %b want 111", obs);
      end
      rstN = 1'b0; opendFlag = 1'b0;
      tick();
      obs = {memWrite, regOut, swEnable};
      checks++;
      if (obs !== 3'b000) begin
         errors++;
         $display("FAIL mrst_abort got %b want 000", obs);
      end
      rstN = 1'b1; storeEnd = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {memWrite, regOut, swEnable};
         checks++;
         if (obs !== 3'b000) begin
            errors++;
            $display("FAIL mrst_idle%0d got %b want 000", i, obs);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstN = 1'b0;
      opendFlag = 1'b0;
      storeEnd = 1'b0;
      test_reset();
      test_entry();
      test_hold();
      test_exit();
      test_min_dwell();
      test_priority();
      test_mid_store_reset();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/store_state_machine.md
# store_state_machine

Two-state Moore controller that sequences a store operation in the memory controller. It waits in IDLE until the operand-ready flag (`opendFlag`) is sampled high, then holds STORE. In STORE it asserts the memory write strobe, the register-file output enable and the store-path switch enable until `storeEnd` is sampled high. It sits between the instruction/operand decode logic and the memory write datapath.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge
- `rstN`  in  1  reset; synchronous and active-low, sampled on rising `clk`
- `opendFlag`  in  1  operands ready; request to begin a store
- `storeEnd`  in  1  store complete; request to return to idle
- `memWrite`  out  1  memory write enable; high only in STORE
- `regOut`  out  1  register-file output enable toward memory data bus; high only in STORE
- `swEnable`  out  1  store-path switch/mux enable; high only in STORE

## Operation
- States: IDLE (encoding 0) and STORE (encoding 1), held in a 1-bit state register.
- IDLE:
  - `opendFlag`=1 → STORE.
  - Otherwise stay in IDLE.
  - `storeEnd` is ignored.
- STORE:
  - `storeEnd`=1 → IDLE.
  - Otherwise stay in STORE, including when `opendFlag` has dropped to 0.
  - `opendFlag` is ignored.
- Simultaneous `opendFlag`=1 and `storeEnd`=1:
  - In IDLE → STORE.
  - In STORE → IDLE (storeEnd has priority).
- Outputs are decoded from the state only (Moore), with no input-to-output combinational path:
  - IDLE: `memWrite`=`regOut`=`swEnable`=0.
  - STORE: all three =1.
- The three outputs are always equal to each other.
- Any illegal or unknown state value → IDLE on the next edge, and the outputs decode as IDLE.

## Timing
- `rstN`=0 at a rising edge → state IDLE and all outputs 0 after that edge.
- Reset overrides every input, including mid-store; a store in progress is aborted with no completion.
- Before the first reset edge the state is undefined; the bench applies reset or treats outputs as X.
- Entry latency: `opendFlag` high at rising edge N → outputs high immediately after edge N (1 cycle from input setup).
- Exit latency: `storeEnd` high at edge M → outputs low after edge M.
- Minimum STORE dwell is 1 cycle; a `storeEnd` already high at the entry edge is not acted on until the next edge.
- Inputs are sampled only at rising `clk`; pulses between edges are not seen.
- Inputs are synchronous to `clk`; no internal synchronizers.

## Structure
- Shared package `mem_ctrl_pkg` holds:
  - state enum `store_state_t` {IDLE=1'b0, STORE=1'b1}
  - constants for the output vector in each state
- Single module with one `always_ff` (state register with synchronous reset) and one `always_comb` (next state plus output decode).
- No sub-module.

## Test plan
- Reset: hold `rstN`=0 for 2 edges with `opendFlag`=1 → state IDLE, outputs 000; release reset → STORE after the next edge.
- Entry: from IDLE, `opendFlag`=1 set mid-cycle before edge N → after edge N `memWrite`/`regOut`/`swEnable`=111.
- Hold: in STORE, drop `opendFlag`=0 with `storeEnd`=0 for 2 cycles → outputs stay 111.
- Exit: in STORE, `storeEnd`=1 before an edge → after the edge outputs 000 and they remain 000 while `opendFlag`=0.
- Priority: in STORE with both inputs =1 → IDLE (000); next edge, still both =1 → STORE (111); verify the toggle continues each cycle.
- Mid-store reset: in STORE, `rstN`=0 at one edge → 000 immediately after; with `storeEnd`=1 in IDLE there is no change.
